deadlock_report_scheduler: RTL
==============================

# deadlock_report_scheduler

Simulation-side controller that collects the per-instance `block` flags from the deadlock monitors in the HLS co-simulation bench. It qualifies each flag by persistence and then serializes the qualified reports to the bench's reporting/termination logic over a valid/ready channel. A round-robin arbiter shares the single report channel among all monitors. A sticky `deadlock` output tells the bench to stop simulation.

## Interface
- `NUM_MON`, default 4: number of monitor `block` inputs (≥2).
- `IDX_W`, default 2: width of the report index; must equal clog2(`NUM_MON`).
- `THRESH`, default 16: consecutive blocked cycles needed to qualify a report (1 ≤ `THRESH` < 2^`CNT_W`).
- `CNT_W`, default 16: width of the persistence counters and of `rpt_cycles`.

Ports (name, direction, width, meaning):
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `mon_block`, in, `NUM_MON`: per-monitor block flag; bit i is monitor i.
- `mon_idle`, in, `NUM_MON`: per-monitor idle flag. An idle monitor never counts as blocked.
- `rpt_valid`, out, 1: a report is presented.
- `rpt_ready`, in, 1: the consumer accepts the report.
- `rpt_idx`, out, `IDX_W`: index of the reported monitor.
- `rpt_cycles`, out, `CNT_W`: persistence count captured at grant.
- `deadlock`, out, 1: sticky; at least one report has been accepted.
- `pending`, out, `NUM_MON`: per-monitor qualified-and-unreported flags, for debug.

## Operation
- Effective block per monitor: eb[i] = `mon_block[i]` & ~`mon_idle[i]`.
- Per-monitor counter cnt[i]:
  - increments on each edge where eb[i]=1, saturating at 2^`CNT_W`-1;
  - clears to 0 on any edge where eb[i]=0.
- pend[i] sets on the edge where eb[i]=1 and cnt[i]==`THRESH`-1 (the `THRESH`-th consecutive sample), provided done[i]=0.
- pend[i] clears on either of:
  - eb[i]=0 (transient withdrawn);
  - grant of monitor i to the channel.
- done[i] sets on grant of monitor i and clears on eb[i]=0. One report per block episode.
- FSM states:
  - IDLE: if any pend bit is set, grant the first set bit searching upward (with wrap) from ptr. At that edge:
    - latch `rpt_idx` and `rpt_cycles` (= cnt[idx] pre-update value);
    - set `rpt_valid`; clear pend[idx]; set done[idx]; go to PRESENT.
  - PRESENT: hold `rpt_valid`, `rpt_idx` and `rpt_cycles` stable until `rpt_valid` & `rpt_ready` at an edge. At that edge:
    - clear `rpt_valid`; set `deadlock`; set ptr = idx+1 (wrap to 0 past `NUM_MON`-1); go to IDLE.
- Arbitration: round-robin; ptr = 0 after reset.
- Simultaneous events:
  - eb dropping in PRESENT does not withdraw the presented report. It only clears done/cnt for that monitor.
  - A pend set in the same edge as a grant is considered at the next IDLE evaluation.
- `deadlock` clears only on reset.

## Timing
- Reset values:
  - `rpt_valid`=0, `rpt_idx`=0, `rpt_cycles`=0, `deadlock`=0, `pending`=0;
  - all cnt, pend and done = 0; ptr=0; FSM=IDLE.
- Reset asserted mid-PRESENT: all outputs take reset values at that edge, and the report is dropped.
- Uncontended latency with eb[i] high from edge 1:
  - pend[i] high after edge `THRESH`;
  - `rpt_valid` high after edge `THRESH`+1;
  - `rpt_cycles`=`THRESH`.
- Handshake:
  - a transfer occurs at an edge with `rpt_valid`=1 and `rpt_ready`=1;
  - `rpt_ready` is ignored when `rpt_valid`=0;
  - the minimum spacing between successive reports is 2 cycles, because IDLE always occupies one cycle.
- Combinational paths: there is no combinational path from any input to any output; all outputs are registered.

## Test plan
- Single monitor qualify (`THRESH`=16):
  - stimulus: `mon_block[2]` held high, `mon_idle`=0, `rpt_ready`=1;
  - response: `rpt_valid` rises after edge 17, `rpt_idx`=2, `rpt_cycles`=16, valid for one cycle; `deadlock`=1 thereafter; no second report while block stays high.
- Transient:
  - stimulus: `mon_block[0]` high for 15 cycles, then low;
  - response: `pending`=0 throughout, no `rpt_valid`, `deadlock`=0.
- Idle mask:
  - stimulus: `mon_block[1]`=1 and `mon_idle[1]`=1 for 100 cycles;
  - response: no report.
- Round-robin with back-pressure:
  - stimulus: all four monitors blocked from the same edge; `rpt_ready`=0 for 5 cycles, then 1;
  - response: reports in index order 0,1,2,3; `rpt_idx` and `rpt_cycles` stable while stalled; reports spaced 2 cycles apart once ready.
- Withdraw during PRESENT:
  - stimulus: `mon_block[3]` drops while its report is stalled;
  - response: the report stays presented and completes; re-asserting block for 16 cycles produces a new report.
- Reset mid-operation:
  - stimulus: reset asserted during PRESENT;
  - response: at the reset edge all outputs = 0, ptr=0; the next qualified report requires a full `THRESH` again.

Source files
------------

// File: rtl/deadlock_report_scheduler.sv
// deadlock_report_scheduler: qualifies per-monitor block flags (mon_block, mon_idle) by persistence and serializes reports round-robin over rpt_valid/rpt_ready with rpt_idx/rpt_cycles, sticky deadlock, debug pending
module deadlock_report_scheduler #(
  parameter int NUM_MON = 4,
  parameter int IDX_W = 2,
  parameter int THRESH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic [NUM_MON-1:0] mon_idle,
  output logic               rpt_valid,
  input  logic               rpt_ready,
  output logic [IDX_W-1:0]   rpt_idx,
  output logic [CNT_W-1:0]   rpt_cycles,
  output logic               deadlock,
  output logic [NUM_MON-1:0] pending
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state;
  logic [NUM_MON-1:0] eb, done, gnt_vec;
  logic [CNT_W-1:0] cnt [NUM_MON];
  logic [IDX_W-1:0] ptr, gnt_idx;
  logic gnt_hit, grant;
  assign eb = mon_block & ~mon_idle;
  always_comb begin
    gnt_hit = |pending;
    gnt_idx = '0;
    for (int k = NUM_MON - 1; k >= 0; k--)
      if (pending[(int'(ptr) + k) % NUM_MON]) gnt_idx = IDX_W'((int'(ptr) + k) % NUM_MON);
  end
  assign grant = state == IDLE && gnt_hit;
  assign gnt_vec = grant ? NUM_MON'(1) << gnt_idx : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
      pending <= '0;
      done <= '0;
      ptr <= '0;
      state <= IDLE;
      rpt_valid <= 1'b0;
      rpt_idx <= '0;
      rpt_cycles <= '0;
      deadlock <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        cnt[i] <= !eb[i] ? '0 : (&cnt[i] ? cnt[i] : cnt[i] + 1'b1);
        pending[i] <= eb[i] && !gnt_vec[i] && (pending[i] || (cnt[i] == CNT_W'(THRESH - 1) && !done[i]));
        done[i] <= eb[i] && (done[i] || gnt_vec[i]);
      end
      if (state == IDLE) begin
        if (gnt_hit) begin
          rpt_idx <= gnt_idx;
          rpt_cycles <= cnt[gnt_idx];
          rpt_valid <= 1'b1;
          state <= PRESENT;
        end
      end else if (rpt_ready) begin
        rpt_valid <= 1'b0;
        deadlock <= 1'b1;
        ptr <= rpt_idx == IDX_W'(NUM_MON - 1) ? '0 : rpt_idx + 1'b1;
        state <= IDLE;
      end
    end
  end
endmodule
